// File: rtl/calram_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : calram_sequencer
// Description : WISHBONE master that runs a calibration-RAM acquisition.
//               A run configures the block, resets and enables it, polls the
//               roll counter and status until the roll target is met or the
//               ZC buffer fills, then disables it.
//               Ports:
//                 clk_i, rst_ni           clock, async active-low reset
//                 start_i, abort_i        run control pulses
//                 mode_i, target_rolls_i  run settings, latched on start
//                 busy_o, done_o,
//                 zc_full_o, err_o        run status
//                 rolls_o                 last roll count read
//                 wbm_*                   WISHBONE master port
//               Optional build macro CALRAM_SEQ_TIMEOUT_EN adds an
//               acknowledge watchdog of ACK_TIMEOUT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module calram_sequencer #(
    parameter int unsigned POLL_INTERVAL = 1024,
    parameter int unsigned ACK_TIMEOUT   = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic        mode_i,
    input  logic [31:0] target_rolls_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        zc_full_o,
    output logic        err_o,
    output logic [31:0] rolls_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [18:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i
);

    localparam logic [18:0] c_ADR_CTRL  = 19'h60000;
    localparam logic [18:0] c_ADR_CFG   = 19'h60004;
    localparam logic [18:0] c_ADR_COUNT = 19'h60008;

    // CFG..RDSTAT are kept contiguous so the abortable range is a compare.
    localparam logic [3:0] c_S_IDLE   = 4'd0;
    localparam logic [3:0] c_S_CFG    = 4'd1;
    localparam logic [3:0] c_S_RST    = 4'd2;
    localparam logic [3:0] c_S_EN     = 4'd3;
    localparam logic [3:0] c_S_WAIT   = 4'd4;
    localparam logic [3:0] c_S_RDCNT  = 4'd5;
    localparam logic [3:0] c_S_RDSTAT = 4'd6;
    localparam logic [3:0] c_S_DIS    = 4'd7;
    localparam logic [3:0] c_S_FIN    = 4'd8;

    logic [3:0]  r_state;
    logic [3:0]  w_state_next;
    logic        r_cyc;
    logic        r_busy;
    logic        r_done;
    logic        r_zc_full;
    logic        r_err;
    logic        r_abort;
    logic        r_mode;
    logic        r_sel_en;
    logic [31:0] r_rolls;
    logic [31:0] r_target;
    logic [15:0] r_poll_cnt;

    logic w_bus_state;
    logic w_abortable;
    logic w_abort_req;
    logic w_ack;
    logic w_err;
    logic w_rty;
    logic w_term;
    logic w_timeout;
    logic w_start;
    logic w_poll_done;

    assign w_bus_state = (r_state == c_S_CFG)   || (r_state == c_S_RST)   ||
                         (r_state == c_S_EN)    || (r_state == c_S_RDCNT) ||
                         (r_state == c_S_RDSTAT)|| (r_state == c_S_DIS);
    assign w_abortable = (r_state >= c_S_CFG) && (r_state <= c_S_RDSTAT);
    // An abort is remembered until the in-flight cycle terminates.
    assign w_abort_req = r_abort || (abort_i && w_abortable);

    // Termination priority: err, then ack, then rty.
    assign w_err  = r_cyc && wbm_err_i;
    assign w_ack  = r_cyc && wbm_ack_i && !wbm_err_i;
    assign w_rty  = r_cyc && wbm_rty_i && !wbm_ack_i && !wbm_err_i;
    assign w_term = w_err || w_ack || w_rty;

    assign w_start     = (r_state == c_S_IDLE) && start_i && !abort_i;
    assign w_poll_done = (r_poll_cnt == 16'(POLL_INTERVAL - 1));

`ifdef CALRAM_SEQ_TIMEOUT_EN
    logic [15:0] r_to_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_to_cnt <= '0;
        end else if (r_cyc && !w_term) begin
            r_to_cnt <= r_to_cnt + 16'd1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    // Fires on the last permitted cycle, so cyc is high ACK_TIMEOUT cycles.
    assign w_timeout = r_cyc && !w_term && (r_to_cnt == 16'(ACK_TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_start) w_state_next = c_S_CFG;
            end
            c_S_WAIT: begin
                if (w_abort_req)      w_state_next = c_S_DIS;
                else if (w_poll_done) w_state_next = c_S_RDCNT;
            end
            c_S_FIN: begin
                w_state_next = c_S_IDLE;
            end
            c_S_CFG, c_S_RST, c_S_EN, c_S_RDCNT, c_S_RDSTAT, c_S_DIS: begin
                if (w_err || w_timeout) begin
                    w_state_next = c_S_FIN;
                end else if (w_ack) begin
                    if (r_state == c_S_DIS) begin
                        w_state_next = c_S_FIN;
                    end else if (w_abort_req) begin
                        w_state_next = c_S_DIS;
                    end else begin
                        case (r_state)
                            c_S_CFG:   w_state_next = c_S_RST;
                            c_S_RST:   w_state_next = c_S_EN;
                            c_S_EN:    w_state_next = c_S_WAIT;
                            c_S_RDCNT: w_state_next = c_S_RDSTAT;
                            default: begin
                                if (wbm_dat_i[2] || (r_rolls >= r_target))
                                    w_state_next = c_S_DIS;
                                else
                                    w_state_next = c_S_WAIT;
                            end
                        endcase
                    end
                end else if (!r_cyc && (r_state != c_S_DIS) && w_abort_req) begin
                    // No cycle in flight (entry or retry gap): skip straight to disable.
                    w_state_next = c_S_DIS;
                end
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    // Datapath, bus strobe and status registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cyc      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_zc_full  <= 1'b0;
            r_err      <= 1'b0;
            r_abort    <= 1'b0;
            r_mode     <= 1'b0;
            r_sel_en   <= 1'b0;
            r_rolls    <= '0;
            r_target   <= '0;
            r_poll_cnt <= '0;
        end else begin
            r_sel_en <= 1'b1;

            // cyc drops the cycle after termination; it is raised again only
            // after a full idle cycle in a state that still owns a transfer.
            if (r_cyc) r_cyc <= !(w_term || w_timeout);
            else       r_cyc <= w_bus_state && (w_state_next == r_state);

            if ((r_state == c_S_WAIT) && (w_state_next == c_S_WAIT))
                r_poll_cnt <= r_poll_cnt + 16'd1;
            else
                r_poll_cnt <= '0;

            if (r_state == c_S_IDLE)         r_abort <= 1'b0;
            else if (abort_i && w_abortable) r_abort <= 1'b1;

            if (w_start) begin
                r_mode    <= mode_i;
                r_target  <= target_rolls_i;
                r_busy    <= 1'b1;
                r_done    <= 1'b0;
                r_zc_full <= 1'b0;
                r_err     <= 1'b0;
                r_rolls   <= '0;
            end

            if ((r_state == c_S_RDCNT) && w_ack)                   r_rolls   <= wbm_dat_i;
            if ((r_state == c_S_RDSTAT) && w_ack && wbm_dat_i[2]) r_zc_full <= 1'b1;
            if (w_err || w_timeout)                                r_err     <= 1'b1;

            if (r_state == c_S_FIN) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    // Output decode: address/data/we depend only on state, so they stay
    // stable for the whole cycle including retries.
    always_comb begin
        wbm_adr_o = '0;
        wbm_dat_o = '0;
        wbm_we_o  = 1'b0;
        case (r_state)
            c_S_CFG: begin
                wbm_adr_o = c_ADR_CFG;
                wbm_dat_o = {29'b0, r_mode, 2'b0};
                wbm_we_o  = 1'b1;
            end
            c_S_RST: begin
                wbm_adr_o = c_ADR_CTRL;
                wbm_dat_o = 32'h2;
                wbm_we_o  = 1'b1;
            end
            c_S_EN: begin
                wbm_adr_o = c_ADR_CTRL;
                wbm_dat_o = 32'h1;
                wbm_we_o  = 1'b1;
            end
            c_S_RDCNT:  wbm_adr_o = c_ADR_COUNT;
            c_S_RDSTAT: wbm_adr_o = c_ADR_CTRL;
            c_S_DIS: begin
                wbm_adr_o = c_ADR_CTRL;
                wbm_we_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign wbm_cyc_o = r_cyc;
    assign wbm_stb_o = r_cyc;
    // Byte selects are 0 only while in reset.
    assign wbm_sel_o = r_sel_en ? 4'hF : 4'h0;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign zc_full_o = r_zc_full;
    assign err_o     = r_err;
    assign rolls_o   = r_rolls;

endmodule
`default_nettype wire
